// File: rtl/jt900h_pfq_pkg.sv
// jt900h_pfq_pkg: shared fetch-FSM encodings and helpers for the JT900H prefetch queue
package jt900h_pfq_pkg;
  typedef enum logic [1:0] {PFQ_IDLE = 2'd0, PFQ_REQ = 2'd1, PFQ_DROP = 2'd2} pfq_st_e;
  function automatic logic [2:0] avail_of(input int cnt);
    return cnt > 4 ? 3'd4 : cnt[2:0];
  endfunction
endpackage

// File: rtl/jt900h_pfq_if.sv
// jt900h_pfq_if: 16-bit opcode fetch bus between the prefetch queue (master) and the bus arbiter (slave)
interface jt900h_pfq_if;
  logic gnt;
  logic rd;
  logic [23:0] addr;
  logic [15:0] din;
  logic ack;
  modport master(input gnt, din, ack, output rd, addr);
  modport slave(output gnt, din, ack, input rd, addr);
endinterface

// File: rtl/jt900h_pfq_ram.sv
// jt900h_pfq_ram: DEPTH x 8 byte ring with two write lanes and four registered read taps
module jt900h_pfq_ram #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wa0,
  input  logic [AW-1:0] wa1,
  input  logic [7:0]    wd0,
  input  logic [7:0]    wd1,
  input  logic [AW-1:0] ra,
  output logic [31:0]   dout
);
  logic [7:0] mem [DEPTH];
  logic [31:0] tap;
  always_ff @(posedge clk) begin
    if (cen) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
    end
  end
  // bytes landing this cycle are forwarded so dout reflects the post-write ring
  for (genvar i = 0; i < 4; i++) begin : g_tap
    logic [AW-1:0] a;
    assign a = ra + AW'(i);
    assign tap[8*i +: 8] = we0 && wa0 == a ? wd0 : we1 && wa1 == a ? wd1 : mem[a];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else if (cen) dout <= tap;
  end
endmodule

// File: rtl/jt900h_pfq.sv
// jt900h_pfq: opcode prefetch queue, presents the next 4 bytes at PC.
// Define JT900H_PFQ_CHK_EN to reject over-reads and flag them on q_err.
module jt900h_pfq import jt900h_pfq_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        flush,
  input  logic [23:0] flush_pc,
  input  logic        q_rd,
  input  logic [1:0]  q_len,
  output logic [31:0] q_dout,
  output logic [2:0]  q_avail,
  output logic        q_err,
  jt900h_pfq_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  pfq_st_e st, st_nxt;
  logic [AW-1:0] rp, rp_nxt, wp, wp_nxt;
  logic [AW:0] cnt, cnt_nxt;
  logic [23:0] fa, fa_nxt, addr_nxt;
  logic [2:0] rd_n, wr_n, avail_nxt;
  logic [7:0] wd0;
  logic rd_nxt, ack_wr, over, we1;
`ifdef JT900H_PFQ_CHK_EN
  assign over = q_rd && ({1'b0, q_len} + 3'd1) > q_avail;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_err <= 1'b0;
    else if (cen) q_err <= over;
  end
`else
  assign over = 1'b0;
  assign q_err = 1'b0;
`endif
  assign rd_n = q_rd && !over ? {1'b0, q_len} + 3'd1 : 3'd0;
  assign ack_wr = st == PFQ_REQ && bus.ack && !flush;
  // an odd fetch address only keeps the upper byte of the word
  assign wr_n = !ack_wr ? 3'd0 : fa[0] ? 3'd1 : 3'd2;
  assign we1 = ack_wr && !fa[0];
  assign wd0 = fa[0] ? bus.din[15:8] : bus.din[7:0];
  assign rp_nxt = flush ? '0 : rp + AW'(rd_n);
  assign wp_nxt = flush ? '0 : wp + AW'(wr_n);
  assign cnt_nxt = flush ? '0 : cnt + (AW+1)'(wr_n) - (AW+1)'(rd_n);
  assign fa_nxt = flush ? flush_pc : fa + 24'(wr_n);
  assign avail_nxt = avail_of(int'(cnt_nxt));
  always_comb begin
    st_nxt = st;
    rd_nxt = bus.rd;
    addr_nxt = bus.addr;
    case (st)
      PFQ_IDLE: if (bus.gnt && !flush && cnt <= (AW+1)'(DEPTH - 2)) begin
        st_nxt = PFQ_REQ;
        rd_nxt = 1'b1;
        addr_nxt = {fa[23:1], 1'b0};
      end
      PFQ_REQ: if (bus.ack) begin
        st_nxt = PFQ_IDLE;
        rd_nxt = 1'b0;
      end else if (flush) st_nxt = PFQ_DROP;
      PFQ_DROP: if (bus.ack) begin
        st_nxt = PFQ_IDLE;
        rd_nxt = 1'b0;
      end
      default: st_nxt = PFQ_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= PFQ_IDLE;
    else if (cen) st <= st_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      fa <= '0;
      bus.rd <= 1'b0;
      bus.addr <= '0;
      q_avail <= '0;
    end else if (cen) begin
      rp <= rp_nxt;
      wp <= wp_nxt;
      cnt <= cnt_nxt;
      fa <= fa_nxt;
      bus.rd <= rd_nxt;
      bus.addr <= addr_nxt;
      q_avail <= avail_nxt;
    end
  end
  jt900h_pfq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .cen(cen),
    .we0(ack_wr),
    .we1(we1),
    .wa0(wp),
    .wa1(wp + AW'(1)),
    .wd0(wd0),
    .wd1(bus.din[15:8]),
    .ra(rp_nxt),
    .dout(q_dout)
  );
endmodule

// File: tb/tb_jt900h_pfq.sv
// tb_jt900h_pfq: scoreboard bench for the prefetch queue against a byte-addressed memory model
module tb_jt900h_pfq;
  logic clk = 0, rst_n = 0, cen = 1, flush = 0, q_rd = 0, ack_hold = 0;
  logic [23:0] flush_pc = '0, pc = '0;
  logic [1:0] q_len = '0;
  logic [31:0] q_dout;
  logic [2:0] q_avail;
  logic q_err;
  int vec = 0, bad = 0;
  logic [23:0] log_q[$];
  typedef struct {logic [31:0] w; logic [31:0] m;} exp_t;
  exp_t sb[$];
  jt900h_pfq_if bus();
  jt900h_pfq #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .flush(flush), .flush_pc(flush_pc),
    .q_rd(q_rd), .q_len(q_len), .q_dout(q_dout), .q_avail(q_avail), .q_err(q_err), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] mb(input logic [23:0] a);
    return a[7:0] * 8'h22 + 8'h12 + a[15:8] + a[23:16];
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // memory responder: acks one cycle after bus_rd unless held
  always @(negedge clk) begin
    if (rst_n && bus.rd && !bus.ack && !ack_hold) begin
      bus.ack = 1'b1;
      bus.din = {mb({bus.addr[23:1], 1'b1}), mb({bus.addr[23:1], 1'b0})};
      log_q.push_back(bus.addr);
      chk("align", 32'(bus.addr[0]), 32'd0);
    end else bus.ack = 1'b0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic consume(input int n);
    exp_t e;
    e.m = n == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    e.w = {mb(pc + 24'd3), mb(pc + 24'd2), mb(pc + 24'd1), mb(pc)} & e.m;
    sb.push_back(e);
    q_rd = 1'b1;
    q_len = 2'(n - 1);
    e = sb.pop_front();
    chk("head", q_dout & e.m, e.w);
    tick;
    q_rd = 1'b0;
    pc = pc + 24'(n);
  endtask
  task automatic do_flush(input logic [23:0] a);
    flush = 1'b1;
    flush_pc = a;
    tick;
    flush = 1'b0;
    pc = a;
    chk("flush_avail", 32'(q_avail), 32'd0);
  endtask
  task automatic wait_avail(input int n);
    for (int k = 0; k < 40 && int'(q_avail) < n; k++) tick;
    chk("wait_avail", 32'(int'(q_avail) >= n), 32'd1);
  endtask
  task automatic wait_log(input int n);
    for (int k = 0; k < 40 && log_q.size() < n; k++) tick;
    chk("wait_log", 32'(log_q.size() >= n), 32'd1);
  endtask
  task automatic settle;
    bus.gnt = 1'b0;
    repeat (6) tick;
    log_q.delete();
  endtask
  initial begin
    bus.gnt = 1'b0;
    repeat (3) tick;
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_dout", q_dout, 32'd0);
    chk("rst_avail", 32'(q_avail), 32'd0);
    chk("rst_err", 32'(q_err), 32'd0);
    rst_n = 1'b1;
    bus.gnt = 1'b1;
    wait_avail(4);
    chk("t1_dout", q_dout, 32'h7856_3412);
    chk("t1_addr0", 32'(log_q[0]), 32'h0);
    chk("t1_addr1", 32'(log_q[1]), 32'h2);
    repeat (20) tick;
    chk("full_rd", 32'(bus.rd), 32'd0);
    chk("full_reqs", 32'(log_q.size()), 32'd4);
    consume(2);
    tick;
    chk("refill_rd", 32'(bus.rd), 32'd1);
    wait_log(5);
    chk("refill_addr", 32'(log_q[4]), 32'h8);
    consume(4);
    repeat (20) tick;
    log_q.delete();
    do_flush(24'h000101);
    wait_log(2);
    chk("odd_addr0", 32'(log_q[0]), 32'h100);
    chk("odd_addr1", 32'(log_q[1]), 32'h102);
    wait_avail(3);
    consume(1);
    consume(2);
    settle;
    ack_hold = 1'b1;
    bus.gnt = 1'b1;
    do_flush(24'h000200);
    for (int k = 0; k < 10 && !bus.rd; k++) tick;
    do_flush(24'h000300);
    repeat (3) tick;
    chk("drop_rd", 32'(bus.rd), 32'd1);
    chk("drop_addr", 32'(bus.addr), 32'h200);
    ack_hold = 1'b0;
    for (int k = 0; k < 10 && bus.rd; k++) tick;
    chk("drop_avail", 32'(q_avail), 32'd0);
    wait_avail(2);
    chk("drop_log0", 32'(log_q[0]), 32'h200);
    chk("drop_log1", 32'(log_q[1]), 32'h300);
    consume(2);
    settle;
    bus.gnt = 1'b1;
    do_flush(24'h000400);
    wait_log(2);
    bus.gnt = 1'b0;
    tick;
    chk("t5_avail4", 32'(q_avail), 32'd4);
    ack_hold = 1'b1;
    bus.gnt = 1'b1;
    tick;
    chk("t5_rd", 32'(bus.rd), 32'd1);
    bus.gnt = 1'b0;
    ack_hold = 1'b0;
    consume(4);
    chk("t5_avail2", 32'(q_avail), 32'd2);
    chk("t5_dout", 32'(q_dout[15:0]), {16'h0, mb(24'h405), mb(24'h404)});
    cen = 1'b0;
    bus.gnt = 1'b1;
    q_rd = 1'b1;
    q_len = 2'd0;
    repeat (3) tick;
    chk("cen_avail", 32'(q_avail), 32'd2);
    chk("cen_rd", 32'(bus.rd), 32'd0);
    q_rd = 1'b0;
    cen = 1'b1;
    consume(2);
`ifdef JT900H_PFQ_CHK_EN
    settle;
    bus.gnt = 1'b1;
    do_flush(24'h000501);
    wait_log(1);
    bus.gnt = 1'b0;
    tick;
    chk("err_avail", 32'(q_avail), 32'd1);
    q_rd = 1'b1;
    q_len = 2'd1;
    tick;
    q_rd = 1'b0;
    chk("err_pulse", 32'(q_err), 32'd1);
    chk("err_keep", 32'(q_avail), 32'd1);
    tick;
    chk("err_clear", 32'(q_err), 32'd0);
    consume(1);
`endif
    settle;
    bus.gnt = 1'b1;
    do_flush(24'hFFFFFD);
    wait_avail(4);
    consume(4);
    wait_log(3);
    chk("wrap_a0", 32'(log_q[0]), 32'hFFFFFC);
    chk("wrap_a1", 32'(log_q[1]), 32'hFFFFFE);
    chk("wrap_a2", 32'(log_q[2]), 32'h0);
    for (int i = 0; i < 400; i++) begin
      int r;
      bus.gnt = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 99);
      if (r < 3) do_flush(r == 0 ? 24'hFFFFFA + 24'($urandom_range(0, 5)) : 24'($urandom));
      else if (r < 60 && q_avail != 3'd0) consume($urandom_range(1, int'(q_avail)));
      else tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
